// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
// UART_RX_PARITY_EN adds the PARITY state to the receiver FSM.
package uart_pkg;

  localparam int unsigned DATA_W = 8;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;
`endif

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module RxSync #(
  parameter logic p_rst_val = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= p_rst_val;
      sync_q <= p_rst_val;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8-bit UART receiver, LSB first, one stop bit, mid-bit sampling.
// Define UART_RX_PARITY_EN to receive and check one even-parity bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned p_clk_freq = 25_000_000,
  parameter int unsigned p_baud     = 115_200
) (
  input  logic              clk_25M,
  input  logic              rst,
  input  logic              rx,
  output logic [DATA_W-1:0] ascii,
  output logic              ascii_val,
  output logic              frame_err,
  output logic              parity_err
);

  localparam int unsigned CPB   = p_clk_freq / p_baud;
  localparam int unsigned CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CPB / 2 > 0) ? (CPB / 2 - 1) : 0);

  logic rx_s;

  RxSync #(.p_rst_val(1'b1)) u_sync (
    .clk (clk_25M),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [2:0]        bit_q,   bit_d;
  logic [DATA_W-1:0] sr_q,    sr_d;
  logic [DATA_W-1:0] ascii_q, ascii_d;
  logic              val_q,   val_d;
  logic              ferr_q,  ferr_d;
`ifdef UART_RX_PARITY_EN
  logic              perr_q,    perr_d;
  logic              par_bad_q, par_bad_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    ascii_d = ascii_q;
    val_d   = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d    = 1'b0;
    par_bad_d = par_bad_q;
`endif
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d = '0;
          sr_d  = {rx_s, sr_q[DATA_W-1:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d     = '0;
          par_bad_d = rx_s ^ (^sr_q);
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d = '0;
          // Leaving at mid-stop-bit lets an immediately following start bit be caught.
          if (!rx_s) begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
`ifdef UART_RX_PARITY_EN
          end else if (par_bad_q) begin
            perr_d  = 1'b1;
            state_d = IDLE;
`endif
          end else begin
            ascii_d = sr_q;
            val_d   = 1'b1;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_25M or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      ascii_q <= '0;
      val_q   <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      ascii_q <= ascii_d;
      val_q   <= val_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      perr_q    <= perr_d;
      par_bad_q <= par_bad_d;
`endif
    end
  end

  assign ascii     = ascii_q;
  assign ascii_val = val_q;
  assign frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at CPB=16; honours UART_RX_PARITY_EN.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned NB = 11;
`else
  localparam int unsigned NB = 10;
`endif
  // A strobe is expected a few cycles (synchronizer + detect) after the stop-bit midpoint.
  localparam int unsigned LAT_LO = (NB - 1) * CPB + CPB / 2;
  localparam int unsigned LAT_SLACK = 4;

  logic       clk_25M = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] ascii;
  logic       ascii_val, frame_err, parity_err;

  int unsigned n_tests = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;
  int unsigned excl_viol = 0;
  logic [7:0]  exp_ascii = 8'h00;

  int unsigned got_kind[$];
  logic [7:0]  got_data[$];
  int unsigned got_cyc[$];
  int unsigned exp_kind[$];
  logic [7:0]  exp_data[$];
  int unsigned exp_lo[$];

  uart_rx #(.p_clk_freq(16), .p_baud(1)) dut (
    .clk_25M    (clk_25M),
    .rst        (rst),
    .rx         (rx),
    .ascii      (ascii),
    .ascii_val  (ascii_val),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #5 clk_25M = ~clk_25M;
  always @(posedge clk_25M) cyc++;

  // Event monitor: 0 = byte, 1 = framing error, 2 = parity error
  always @(negedge clk_25M) begin
    if ((int'(ascii_val) + int'(frame_err) + int'(parity_err)) > 1) excl_viol++;
    if (ascii_val === 1'b1) begin got_kind.push_back(0); got_data.push_back(ascii); got_cyc.push_back(cyc); end
    if (frame_err === 1'b1) begin got_kind.push_back(1); got_data.push_back(ascii); got_cyc.push_back(cyc); end
    if (parity_err === 1'b1) begin got_kind.push_back(2); got_data.push_back(ascii); got_cyc.push_back(cyc); end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d tests run, required completion", n_tests);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic wait_cycles(input int unsigned n);
    repeat (n) @(posedge clk_25M);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    wait_cycles(CPB);
  endtask

  task automatic clear_q();
    got_kind.delete(); got_data.delete(); got_cyc.delete();
    exp_kind.delete(); exp_data.delete(); exp_lo.delete();
  endtask

  // Drives one frame and records the outcome the receiver must report for it.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
    int unsigned t0;
    int unsigned k;
    t0 = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ par_flip);
`endif
    drive_bit(stop_bit);
    if (!stop_bit) k = 1;
`ifdef UART_RX_PARITY_EN
    else if (par_flip) k = 2;
`endif
    else k = 0;
    if (k == 0) exp_ascii = b;
    exp_kind.push_back(k);
    exp_data.push_back(exp_ascii);
    exp_lo.push_back(t0 + LAT_LO);
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1;
    wait_cycles(3);
    n_tests++; if (ascii !== 8'h00) begin n_fail++; $display("FAIL reset_ascii: got %h want 00", ascii); end
    n_tests++; if (ascii_val !== 1'b0) begin n_fail++; $display("FAIL reset_val: got %b want 0", ascii_val); end
    n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    n_tests++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b want 0", parity_err); end
    n_tests++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", dut.state_q); end
    rst = 1'b0;
    exp_ascii = 8'h00;
    wait_cycles(4);
  endtask

  task automatic test_single();
    clear_q();
    send_frame(8'h41, 1'b1, 1'b0);
    rx = 1'b1; wait_cycles(2 * CPB);
    n_tests++; if (got_kind.size() !== 1) begin n_fail++; $display("FAIL single_count: got %0d events want 1", got_kind.size()); end
    else begin
      n_tests++; if (got_kind[0] !== 0) begin n_fail++; $display("FAIL single_kind: got %0d want 0", got_kind[0]); end
      n_tests++; if (got_data[0] !== 8'h41) begin n_fail++; $display("FAIL single_data: got %h want 41", got_data[0]); end
      n_tests++; if (got_cyc[0] < exp_lo[0] || got_cyc[0] > exp_lo[0] + LAT_SLACK) begin
        n_fail++; $display("FAIL single_time: got cycle %0d want %0d..%0d", got_cyc[0], exp_lo[0], exp_lo[0] + LAT_SLACK);
      end
    end
    n_tests++; if (ascii !== 8'h41) begin n_fail++; $display("FAIL single_hold: got %h want 41", ascii); end
  endtask

  task automatic test_glitch();
    clear_q();
    rx = 1'b0; wait_cycles(4);
    rx = 1'b1; wait_cycles(3 * CPB);
    n_tests++; if (got_kind.size() !== 0) begin n_fail++; $display("FAIL glitch_count: got %0d events want 0", got_kind.size()); end
    n_tests++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL glitch_state: got %0d want IDLE", dut.state_q); end
  endtask

  task automatic test_frame_err();
    clear_q();
    send_frame(8'h55, 1'b0, 1'b0);
    wait_cycles(40);
    n_tests++; if (got_kind.size() !== 1) begin n_fail++; $display("FAIL ferr_count: got %0d events want 1", got_kind.size()); end
    else begin
      n_tests++; if (got_kind[0] !== 1) begin n_fail++; $display("FAIL ferr_kind: got %0d want 1", got_kind[0]); end
      n_tests++; if (got_data[0] !== exp_ascii) begin n_fail++; $display("FAIL ferr_ascii: got %h want %h", got_data[0], exp_ascii); end
    end
    n_tests++; if (dut.state_q !== WAIT_IDLE) begin n_fail++; $display("FAIL ferr_wait: got %0d want WAIT_IDLE", dut.state_q); end
    rx = 1'b1; wait_cycles(5);
    n_tests++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL ferr_release: got %0d want IDLE", dut.state_q); end
    n_tests++; if (ascii !== exp_ascii) begin n_fail++; $display("FAIL ferr_hold: got %h want %h", ascii, exp_ascii); end
  endtask

  task automatic test_back_to_back();
    clear_q();
    send_frame(8'h48, 1'b1, 1'b0);
    send_frame(8'h49, 1'b1, 1'b0);
    rx = 1'b1; wait_cycles(2 * CPB);
    n_tests++; if (got_kind.size() !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d events want 2", got_kind.size()); end
    else begin
      n_tests++; if (got_kind[0] !== 0 || got_data[0] !== 8'h48) begin n_fail++; $display("FAIL b2b_first: got kind %0d data %h want kind 0 data 48", got_kind[0], got_data[0]); end
      n_tests++; if (got_kind[1] !== 0 || got_data[1] !== 8'h49) begin n_fail++; $display("FAIL b2b_second: got kind %0d data %h want kind 0 data 49", got_kind[1], got_data[1]); end
      n_tests++; if (got_cyc[1] - got_cyc[0] !== NB * CPB) begin n_fail++; $display("FAIL b2b_spacing: got %0d cycles want %0d", got_cyc[1] - got_cyc[0], NB * CPB); end
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    clear_q();
    b = 8'h7E;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(b[i]);
    rx = b[3]; wait_cycles(CPB / 2);
    rst = 1'b1; wait_cycles(3);
    rx = 1'b1; rst = 1'b0;
    exp_ascii = 8'h00;
    wait_cycles(2 * CPB);
    n_tests++; if (got_kind.size() !== 0) begin n_fail++; $display("FAIL rstmid_abort: got %0d events want 0", got_kind.size()); end
    send_frame(8'h31, 1'b1, 1'b0);
    rx = 1'b1; wait_cycles(2 * CPB);
    n_tests++; if (got_kind.size() !== 1 || got_data[0] !== 8'h31) begin
      n_fail++; $display("FAIL rstmid_next: got %0d events first data %h want 1 event data 31", got_kind.size(), (got_data.size() > 0) ? got_data[0] : 8'hxx);
    end
    clear_q();
    rx = 1'b0; rst = 1'b1; wait_cycles(3);
    rst = 1'b0;
    exp_ascii = 8'h00;
    send_frame(8'hA5, 1'b1, 1'b0);
    rx = 1'b1; wait_cycles(2 * CPB);
    n_tests++; if (got_kind.size() !== 1 || got_data[0] !== 8'hA5) begin
      n_fail++; $display("FAIL rstlow_frame: got %0d events first data %h want 1 event data a5", got_kind.size(), (got_data.size() > 0) ? got_data[0] : 8'hxx);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    clear_q();
    send_frame(8'h03, 1'b1, 1'b1);
    rx = 1'b1; wait_cycles(2 * CPB);
    n_tests++; if (got_kind.size() !== 1) begin n_fail++; $display("FAIL parity_count: got %0d events want 1", got_kind.size()); end
    else begin
      n_tests++; if (got_kind[0] !== 2) begin n_fail++; $display("FAIL parity_kind: got %0d want 2", got_kind[0]); end
    end
    n_tests++; if (ascii !== exp_ascii) begin n_fail++; $display("FAIL parity_hold: got %h want %h", ascii, exp_ascii); end
  endtask
`endif

  task automatic test_random();
    logic [7:0] b;
    logic       stop_ok, pflip;
    int unsigned gap;
    clear_q();
    for (int n = 0; n < 40; n++) begin
      b = 8'($urandom);
      stop_ok = ($urandom_range(0, 5) != 0);
      pflip = ($urandom_range(0, 4) == 0);
`ifndef UART_RX_PARITY_EN
      pflip = 1'b0;
`endif
      send_frame(b, stop_ok, pflip);
      gap = stop_ok ? $urandom_range(0, 20) : 2 + $urandom_range(0, 20);
      rx = 1'b1;
      if (gap > 0) wait_cycles(gap);
    end
    rx = 1'b1; wait_cycles(2 * CPB);
    n_tests++; if (got_kind.size() !== exp_kind.size()) begin
      n_fail++; $display("FAIL rand_count: got %0d events want %0d", got_kind.size(), exp_kind.size());
    end else begin
      for (int i = 0; i < exp_kind.size(); i++) begin
        n_tests++;
        if (got_kind[i] !== exp_kind[i] || got_data[i] !== exp_data[i] ||
            got_cyc[i] < exp_lo[i] || got_cyc[i] > exp_lo[i] + LAT_SLACK) begin
          n_fail++;
          $display("FAIL rand_event[%0d]: got kind %0d data %h cycle %0d want kind %0d data %h cycle %0d..%0d",
                   i, got_kind[i], got_data[i], got_cyc[i], exp_kind[i], exp_data[i], exp_lo[i], exp_lo[i] + LAT_SLACK);
        end
      end
    end
    n_tests++; if (ascii !== exp_ascii) begin n_fail++; $display("FAIL rand_hold: got %h want %h", ascii, exp_ascii); end
  endtask

  task automatic test_exclusive();
    n_tests++; if (excl_viol !== 0) begin n_fail++; $display("FAIL exclusive: got %0d overlapping cycles want 0", excl_viol); end
  endtask

  initial begin
    wait_cycles(1);
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    test_exclusive();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
